// File: rtl/sigmoid_sched.sv
// -----------------------------------------------------------------------------
// sigmoid_sched
//
// Round-robin scheduler sharing one sigmoid_approx unit between num_req neuron
// requesters. One operation is in flight at a time:
//   IDLE  -> grant one requester and capture its operand
//   ISSUE -> drive the unit with a 2-cycle start pulse
//   WAIT  -> wait for the unit's result (stale results are ignored in ISSUE)
//   RESP  -> hold the tagged result on a backpressured response channel
//
// Optional feature macro: SIGMOID_SCHED_TIMEOUT_EN
//   Defined  : WAIT aborts after timeout_cycles with a qNaN / invalid response.
//   Undefined: WAIT holds until the unit answers; rsp_timeout is tied to 0.
//
// Ports
//   clk, rst_l          clock, synchronous active-low reset
//   req_valid/req_x     per-requester operand handshake (packed operands)
//   req_ready           one-hot accept, only asserted in IDLE
//   sig_in_x/valid      operand and start pulse to the sigmoid unit
//   sig_out/exceptions  result and flags from the sigmoid unit
//   sig_out_valid       result strobe from the sigmoid unit
//   rsp_valid/ready     response handshake
//   rsp_id/data         requester index and result
//   rsp_exceptions      captured exception flags
//   rsp_timeout         response produced by a timeout abort
//   busy                high in any state other than IDLE
// -----------------------------------------------------------------------------
module sigmoid_sched #(
    parameter  int exp_width      = 8,
    parameter  int mant_width     = 24,
    parameter  int num_req        = 4,
    parameter  int timeout_cycles = 64,
    localparam int W              = exp_width + mant_width,
    localparam int IW             = $clog2(num_req)
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [num_req-1:0]   req_valid,
    input  logic [num_req*W-1:0] req_x,
    output logic [num_req-1:0]   req_ready,
    output logic [W-1:0]         sig_in_x,
    output logic                 sig_in_valid,
    input  logic [W-1:0]         sig_out,
    input  logic [4:0]           sig_exceptions,
    input  logic                 sig_out_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic [4:0]           rsp_exceptions,
    output logic                 rsp_timeout,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [num_req-1:0] ONE_HOT0 = num_req'(1);

    state_t        r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [W-1:0]  r_x_hold;
    logic [IW-1:0] r_id_hold;
    logic          r_issue_2nd;     // second of the two ISSUE cycles
    logic          r_sig_in_valid;
    logic          r_busy;
    logic          r_rsp_valid;
    logic [W-1:0]  r_rsp_data;
    logic [4:0]    r_rsp_exc;

`ifdef SIGMOID_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(timeout_cycles - 1);
    localparam logic [W-1:0] QNAN   = W'(32'h7FC0_0000);
    logic [15:0] r_cnt;
    logic        r_rsp_timeout;
`endif

    logic          w_found;
    logic [IW-1:0] w_grant_id;
    logic [IW-1:0] w_idx;

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable (no latch).
        w_found    = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int k = 0; k < num_req; k++) begin
            w_idx = IW'((int'(r_rr_ptr) + k) % num_req);
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE && w_found) ? (ONE_HOT0 << w_grant_id) : '0;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_x_hold       <= '0;
            r_id_hold      <= '0;
            r_issue_2nd    <= 1'b0;
            r_sig_in_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_exc      <= '0;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
            r_cnt          <= '0;
            r_rsp_timeout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // req_ready already includes req_valid, so any bit is a handshake.
                    if (|req_ready) begin
                        r_x_hold       <= req_x[w_grant_id*W +: W];
                        r_id_hold      <= w_grant_id;
                        r_issue_2nd    <= 1'b0;
                        r_sig_in_valid <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
                        r_cnt          <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    // sig_out_valid is deliberately not looked at here: it may
                    // belong to the previous operand still draining from the unit.
                    if (r_issue_2nd) begin
                        r_sig_in_valid <= 1'b0;
                        r_state        <= S_WAIT;
                    end else begin
                        r_issue_2nd <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (sig_out_valid) begin
                        r_rsp_data    <= sig_out;
                        r_rsp_exc     <= sig_exceptions;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
`ifdef SIGMOID_SCHED_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
                    end else if (r_cnt == TO_LAST) begin
                        // Last allowed WAIT cycle with no result: abort with qNaN.
                        r_rsp_data    <= QNAN;
                        r_rsp_exc     <= 5'b10000;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        // The requester just served drops to lowest priority.
                        r_rr_ptr    <= (r_id_hold == IW'(num_req - 1)) ? '0 : r_id_hold + 1'b1;
                        r_x_hold    <= '0;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sig_in_x       = r_x_hold;   // cleared on return to IDLE
    assign sig_in_valid   = r_sig_in_valid;
    assign busy           = r_busy;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_id_hold;
    assign rsp_data       = r_rsp_data;
    assign rsp_exceptions = r_rsp_exc;

`ifdef SIGMOID_SCHED_TIMEOUT_EN
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
    // timeout_cycles only matters for the abort path; sink it here.
    logic w_unused_cfg;
    assign w_unused_cfg = (timeout_cycles > 0);
`endif

endmodule

// File: tb/tb_sigmoid_sched.sv
`timescale 1ns/1ps
module tb_sigmoid_sched;

`ifdef SIGMOID_SCHED_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 64;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_l = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*W-1:0] req_x = '0;
    logic [NR-1:0]   req_ready;
    logic [W-1:0]    sig_in_x;
    logic            sig_in_valid;
    logic [W-1:0]    sig_out;
    logic [4:0]      sig_exceptions;
    logic            sig_out_valid;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_data;
    logic [4:0]      rsp_exceptions;
    logic            rsp_timeout;
    logic            busy;

    // Unit model outputs plus an injected stray strobe.
    logic         model_valid = 1'b0;
    logic [W-1:0] model_data = '0;
    logic [4:0]   model_exc = '0;
    logic         inj_valid = 1'b0;

    assign sig_out_valid  = model_valid | inj_valid;
    assign sig_out        = inj_valid ? 32'hDEADBEEF : model_data;
    assign sig_exceptions = inj_valid ? 5'b11111 : model_exc;

    always #5 clk = ~clk;

    sigmoid_sched #(
        .exp_width(8), .mant_width(24), .num_req(NR), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .sig_in_x(sig_in_x), .sig_in_valid(sig_in_valid),
        .sig_out(sig_out), .sig_exceptions(sig_exceptions), .sig_out_valid(sig_out_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_exceptions(rsp_exceptions),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT event within cycle budget", name);
    endtask

    // Stand-in unit function and flags.
    function automatic logic [W-1:0] unit_fn(input logic [W-1:0] x);
        return x ^ 32'h3F000000;
    endfunction
    function automatic logic [4:0] exc_fn(input logic [W-1:0] x);
        return x[4:0] ^ 5'b00011;
    endfunction

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic [4:0]    exc;
        logic          to;
    } exp_t;

    exp_t sb[$];

    int          cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor, unit model and scoreboard, all sampled on the falling edge.
    int           unit_lat = 0;     // WAIT cycles before the unit answers; <0 = never
    logic         prev_siv = 1'b0;
    logic         in_wait = 1'b0;
    int           wcnt = 0;
    int           siv_cnt = 0;
    logic [W-1:0] unit_x = '0;
    logic [W-1:0] cur_x = '0;
    int           acc_cyc = 0;
    int           cur_lat = -1;
    int           last_lat = -1;
    logic         lat_pend = 1'b0;

    always @(negedge clk) begin
        if (!rst_l) begin
            sb.delete();
            model_valid = 1'b0;
            prev_siv    = 1'b0;
            in_wait     = 1'b0;
            lat_pend    = 1'b0;
        end else begin
            if (rsp_valid && lat_pend) begin
                lat_pend = 1'b0;
                last_lat = cyc + 1 - acc_cyc;
                if (cur_lat >= 0) check("latency", last_lat, cur_lat);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_exc", rsp_exceptions, e.exc);
                    check("rsp_timeout", rsp_timeout, e.to);
                end
            end
            if ((req_valid & req_ready) != '0) begin
                exp_t e;
                int g;
                g = 0;
                for (int i = 0; i < NR; i++) if (req_valid[i] & req_ready[i]) g = i;
                cur_x  = req_x[g*W +: W];
                e.id   = IW'(g);
                if (unit_lat < 0 && TO_EN) begin
                    e.data = 32'h7FC00000;
                    e.exc  = 5'b10000;
                    e.to   = 1'b1;
                end else begin
                    e.data = unit_fn(cur_x);
                    e.exc  = exc_fn(cur_x);
                    e.to   = 1'b0;
                end
                sb.push_back(e);
                acc_cyc  = cyc + 1;
                cur_lat  = (unit_lat >= 0) ? 4 + unit_lat : (TO_EN ? 3 + TO : -1);
                lat_pend = 1'b1;
                siv_cnt  = 0;
            end
            // Unit model: latch operand during the start pulse, answer after unit_lat WAIT cycles.
            if (sig_in_valid) begin
                siv_cnt++;
                check("sig_in_x", sig_in_x, cur_x);
                unit_x = sig_in_x;
            end
            model_valid = 1'b0;
            if (prev_siv && !sig_in_valid) begin
                check("issue_len", siv_cnt, 2);
                in_wait = 1'b1;
                wcnt    = 0;
            end
            if (in_wait) begin
                if (unit_lat >= 0 && wcnt == unit_lat) begin
                    model_valid = 1'b1;
                    model_data  = unit_fn(unit_x);
                    model_exc   = exc_fn(unit_x);
                    in_wait     = 1'b0;
                end else begin
                    wcnt++;
                end
            end
            prev_siv = sig_in_valid;
        end
    end

    // Present mask, wait for the accept, return the granted index.
    task automatic issue(input logic [NR-1:0] mask, input int lat, output int g);
        unit_lat  = lat;
        req_valid = mask;
        g = -1;
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) begin
                check("grant_onehot", $countones(req_ready), 1);
                for (int k = 0; k < NR; k++) if (req_ready[k]) g = k;
            end
        end
        if (g < 0) bound_expired("accept_wait");
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    // Wait for the response handshake (rsp_ready already high).
    task automatic wait_rsp(output logic [W-1:0] data);
        logic done;
        done = 1'b0;
        data = '0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                data = rsp_data;
                done = 1'b1;
            end
        end
        if (!done) bound_expired("rsp_wait");
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        int            lat;
        int            exp_g;
    } vec_t;

    vec_t tbl[11];
    logic [W-1:0] xs[NR];

    initial begin : main
        int g;
        logic [W-1:0] d;
        logic [W+IW+5:0] snap;

        xs[0] = 32'h3F800000; xs[1] = 32'h40000000;
        xs[2] = 32'hBF800000; xs[3] = 32'hC0000000;
        for (int i = 0; i < NR; i++) req_x[i*W +: W] = xs[i];

        // Fairness run from rr_ptr=0, then pointer-relative patterns.
        tbl[0]  = '{4'b1111, 0, 0};
        tbl[1]  = '{4'b1111, 1, 1};
        tbl[2]  = '{4'b1111, 2, 2};
        tbl[3]  = '{4'b1111, 3, 3};
        tbl[4]  = '{4'b1111, 0, 0};
        tbl[5]  = '{4'b0101, 1, 2};
        tbl[6]  = '{4'b0101, 4, 0};
        tbl[7]  = '{4'b1000, 0, 3};
        tbl[8]  = '{4'b0110, 2, 1};
        tbl[9]  = '{4'b0010, 1, 1};
        tbl[10] = '{4'b1001, 3, 3};

        // Reset values.
        rst_l = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_sig_in_x", sig_in_x, 0);
        check("rst_sig_in_valid", sig_in_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_exc", rsp_exceptions, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_l = 1'b1;

        // Table-driven grants; response contents checked by the scoreboard.
        for (int v = 0; v < 11; v++) begin
            issue(tbl[v].mask, tbl[v].lat, g);
            check($sformatf("grant_v%0d", v), g, tbl[v].exp_g);
            wait_rsp(d);
            @(negedge clk);
            check("idle_sig_in_x", sig_in_x, 0);
            check("idle_busy", busy, 0);
            @(posedge clk);
            #1;
        end

        // Single request: x=0, unit answers after 5 WAIT cycles.
        req_x[0 +: W] = 32'h00000000;
        issue(4'b0001, 5, g);
        check("single_grant", g, 0);
        wait_rsp(d);
        check("single_data", d, 32'h3F000000);
        check("single_latency", last_lat, 9);
        req_x[0 +: W] = xs[0];

        // Backpressure with stale strobe during ISSUE.
        rsp_ready = 1'b0;
        issue(4'b0010, 2, g);
        check("bp_grant", g, 1);
        inj_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 inj_valid = 1'b0;
        req_valid = 4'b1101;
        begin : bp_wait
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            if (!seen) bound_expired("bp_rsp_wait");
        end
        snap = {rsp_id, rsp_data, rsp_exceptions, rsp_timeout};
        check("bp_data", rsp_data, unit_fn(xs[1]));
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {rsp_valid, req_ready, rsp_id, rsp_data, rsp_exceptions, rsp_timeout},
                  {1'b1, 4'b0000, snap});
            @(posedge clk);
            if (i == 9) #1 rsp_ready = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("bp_done_busy", busy, 0);
        @(posedge clk);
        #1;

        // Reset mid-WAIT, late strobe in IDLE, then a normal request.
        issue(4'b0001, -1, g);
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b0;
        @(posedge clk);
        #1 rst_l = 1'b1;
        inj_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sig_in_x", sig_in_x, 0);
        @(posedge clk);
        #1 inj_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_valid_ignored", {rsp_valid, busy}, 2'b00);
        end
        @(posedge clk);
        #1;
        issue(4'b0100, 1, g);
        check("post_rst_grant", g, 2);
        wait_rsp(d);
        check("post_rst_data", d, unit_fn(xs[2]));

`ifdef SIGMOID_SCHED_TIMEOUT_EN
        // Unit never answers: abort after TO WAIT cycles.
        issue(4'b0001, -1, g);
        wait_rsp(d);
        check("to_data", d, 32'h7FC00000);
        check("to_latency", last_lat, 3 + TO);
`endif

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sigmoid_sched.md
# sigmoid_sched

Round-robin scheduler that shares one `sigmoid_approx` unit between `num_req` neuron requesters. It accepts one operand at a time through per-requester valid/ready handshakes and drives the unit's input with a 2-cycle valid pulse. It then waits for the unit's `out_valid` and returns the result, tagged with the requester ID, on a single backpressured response channel. It sits between the neuron accumulators and the shared activation datapath.

## Interface
- `exp_width`, 8, exponent width of the FP operand.
- `mant_width`, 24, mantissa width; word width W = exp_width + mant_width.
- `num_req`, 4, number of requesters (2..8); ID width IW = $clog2(num_req).
- `timeout_cycles`, 64, maximum WAIT cycles before abort (only used with the timeout feature).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_l` in 1: reset, synchronous, active-low.
- `req_valid` in num_req: per-requester operand valid.
- `req_x` in num_req*W: packed operands; requester i uses `req_x[i*W +: W]`.
- `req_ready` out num_req: one-hot grant/accept.
- `sig_in_x` out W: operand to the sigmoid unit.
- `sig_in_valid` out 1: start pulse to the sigmoid unit.
- `sig_out` in W: result from the sigmoid unit.
- `sig_exceptions` in 5: exception flags from the sigmoid unit.
- `sig_out_valid` in 1: sigmoid result valid.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out IW: requester index for the response.
- `rsp_data` out W: sigmoid result.
- `rsp_exceptions` out 5: captured exception flags.
- `rsp_timeout` out 1: response was produced by a timeout abort.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. One operation is in flight at a time.
- **IDLE:**
  - Grant = the first asserted `req_valid` at or after the round-robin pointer `rr_ptr`, searching upward with wrap.
  - `req_ready` = one-hot grant, combinational, asserted only in IDLE.
  - On `req_valid[g] & req_ready[g]`: capture operand into `x_hold` and g into `id_hold`, clear the cycle counter, go to ISSUE.
- **ISSUE:**
  - Lasts exactly 2 cycles with `sig_in_valid`=1; `sig_in_x`=`x_hold`.
  - Then go to WAIT. `sig_out_valid` is ignored during ISSUE, because it may be a stale result from the previous operand.
- **WAIT:**
  - `sig_in_x` stays at `x_hold`; `sig_in_valid`=0.
  - On `sig_out_valid`=1: capture `sig_out` into `rsp_data` and `sig_exceptions` into `rsp_exceptions`, go to RESP.
- **RESP:**
  - `rsp_valid`=1; `rsp_id`, `rsp_data`, `rsp_exceptions` and `rsp_timeout` are held stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: `rr_ptr` <= (`id_hold`+1) mod num_req, go to IDLE.
- `rr_ptr` changes only on response completion, so a requester granted last has lowest priority next time.
- `sig_in_x` is 0 in IDLE.
- Requesters keep `req_valid` and `req_x` stable until accepted; the scheduler never drops an accepted operand.
- Reset (`rst_l`=0 at an edge), including mid-operation:
  - state=IDLE, `rr_ptr`=0, `x_hold`=0, `id_hold`=0, counter=0.
  - All outputs 0: `req_ready`, `sig_in_x`, `sig_in_valid`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_exceptions`, `rsp_timeout`, `busy`.
  - An in-flight operation is dropped; a late `sig_out_valid` arriving in IDLE is ignored.

## Timing
- Accept at edge T0 → `sig_in_valid`=1 during cycles T0+1 and T0+2 → WAIT from T0+3.
- Capture at the first `sig_out_valid` edge in WAIT; `rsp_valid` is visible the next cycle.
- Minimum accept-to-`rsp_valid` latency is 4 cycles (unit responds in the first WAIT cycle). Total latency = 3 + unit latency + 1.
- Back-to-back throughput: the next accept can occur the cycle after the response handshake (IDLE lasts ≥1 cycle).
- Simultaneous events:
  - `rsp_ready` held at 1 completes the response in the first RESP cycle.
  - New `req_valid` arriving during non-IDLE states waits; `req_ready` stays 0.

## Configuration
- `SIGMOID_SCHED_TIMEOUT_EN` defined:
  - A 16-bit counter increments each WAIT cycle.
  - When it reaches `timeout_cycles` without `sig_out_valid`, go to RESP with `rsp_data`=32'h7FC00000 (qNaN), `rsp_exceptions`=5'b10000 (invalid), `rsp_timeout`=1.
  - If `sig_out_valid` and expiry occur in the same cycle, the valid result wins.
- Not defined: no counter; WAIT holds indefinitely; `rsp_timeout` is tied to 0.

## Test plan
- **Reset values:** assert `rst_l`=0 for 2 cycles → every output is 0 and `busy`=0.
- **Single request:** `req_valid`=4'b0001, x=0x00000000; unit model responds 0x3F000000 after 5 WAIT cycles; `rsp_ready`=1 → `sig_in_valid` high exactly 2 cycles; `rsp_valid` with id=0, data=0x3F000000 arrives 9 cycles after accept.
- **Round-robin fairness:** all four requesters held valid (x=0x3F800000, 0x40000000, 0xBF800000, 0xC0000000) → grants in order 0,1,2,3,0; each response id matches its operand.
- **Backpressure and stale valid:** `rsp_ready`=0 for 10 RESP cycles → outputs stable and `req_ready`=0 throughout. `sig_out_valid` pulsed during ISSUE → ignored.
- **Reset mid-WAIT:** reset in WAIT, then `sig_out_valid` arrives in IDLE → no response; the next request (id 2) completes normally.
- **Timeout (macro defined):** `timeout_cycles`=8, unit never responds → `rsp_valid` after 8 WAIT cycles with `rsp_timeout`=1, data 0x7FC00000, exceptions 5'b10000.
